// File: rtl/ycr1_dmem_sram_resp_if.sv
// Core dmem request/response bundle between a requester (router port) and a responder.
`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif

interface ycr1_dmem_sram_resp_if;
    logic                          dmem_req_ack;
    logic                          dmem_req;
    logic                          dmem_cmd;
    logic [1:0]                    dmem_width;
    logic [`YCR1_DMEM_AWIDTH-1:0]  dmem_addr;
    logic [`YCR1_DMEM_DWIDTH-1:0]  dmem_wdata;
    logic [`YCR1_DMEM_DWIDTH-1:0]  dmem_rdata;
    logic [1:0]                    dmem_resp;

    modport master (
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/ycr1_dmem_sram_resp.sv
// Data-memory responder driving a single-port synchronous SRAM with configurable wait states.
// Define YCR1_DMEM_SRAM_ALIGN_CHK_EN to reject misaligned halfword/word accesses with RDY_ER.
`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif

module ycr1_dmem_sram_resp #(
    parameter int                           SRAM_AWIDTH  = 9,
    parameter logic [`YCR1_DMEM_AWIDTH-1:0] ADDR_MASK    = `YCR1_DMEM_AWIDTH'hFFFF0000,
    parameter logic [`YCR1_DMEM_AWIDTH-1:0] ADDR_PATTERN = `YCR1_DMEM_AWIDTH'h00010000,
    parameter int                           WAIT_STATES  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    ycr1_dmem_sram_resp_if.slave   dmem,
    output logic                   sram_csb,
    output logic                   sram_web,
    output logic [3:0]             sram_wmask,
    output logic [SRAM_AWIDTH-1:0] sram_addr,
    output logic [31:0]            sram_din,
    input  logic [31:0]            sram_dout
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [1:0] WS = 2'(WAIT_STATES);

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;

    logic       accept;
    logic       range_err, width_err, align_err, err_p0;
    logic [1:0] off_p0;
    logic       sram_en;

    logic       cmd_p1, err_p1;
    logic [1:0] off_p1, width_p1;
    logic [31:0] rd_word;
    logic       resp_vld;

    function automatic logic [3:0] lane_mask(input logic [1:0] w, input logic [1:0] o);
        case (w)
            2'b00:   lane_mask = 4'b0001 << o;
            2'b01:   lane_mask = 4'b0011 << o;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] rd_align(input logic [31:0] word, input logic [1:0] w,
                                             input logic [1:0] o);
        logic [31:0] sh;
        sh = word >> {o, 3'b000};
        case (w)
            2'b00:   rd_align = sh & 32'h0000_00FF;
            2'b01:   rd_align = sh & 32'h0000_FFFF;
            default: rd_align = sh;
        endcase
    endfunction

    // Stage p0: request decode and combinational SRAM drive in the accept cycle
    assign dmem.dmem_req_ack = !rst && (state == IDLE || state == RESP);
    assign accept            = dmem.dmem_req && dmem.dmem_req_ack;
    assign range_err         = (dmem.dmem_addr & ADDR_MASK) != ADDR_PATTERN;
    assign width_err         = dmem.dmem_width == 2'b11;

    always_comb begin
        off_p0    = dmem.dmem_addr[1:0];
        align_err = 1'b0;
        case (dmem.dmem_width)
            2'b01: begin
                off_p0 = {dmem.dmem_addr[1], 1'b0};
`ifdef YCR1_DMEM_SRAM_ALIGN_CHK_EN
                align_err = dmem.dmem_addr[0];
`endif
            end
            2'b10: begin
                off_p0 = 2'b00;
`ifdef YCR1_DMEM_SRAM_ALIGN_CHK_EN
                align_err = |dmem.dmem_addr[1:0];
`endif
            end
            default: ;
        endcase
    end

    assign err_p0     = range_err || width_err || align_err;
    assign sram_en    = accept && !err_p0;
    assign sram_csb   = !sram_en;
    assign sram_web   = !(sram_en && dmem.dmem_cmd);
    assign sram_wmask = sram_en ? lane_mask(dmem.dmem_width, off_p0) : 4'b0000;
    assign sram_addr  = sram_en ? dmem.dmem_addr[SRAM_AWIDTH+1:2] : '0;
    assign sram_din   = sram_en ? (32'(dmem.dmem_wdata) << {off_p0, 3'b000}) : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WS;
                    end
                end else if (state == RESP) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 2'd1;
                if (cnt <= 2'd1) begin
                    state_nxt = RESP;
                    cnt_nxt   = 2'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: transfer attributes held until the response is presented
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_p1   <= dmem.dmem_cmd;
            err_p1   <= err_p0;
            off_p1   <= off_p0;
            width_p1 <= dmem.dmem_width;
        end
    end

    // Stage p2: SRAM read word, registered only when wait states stretch the response
    generate
        if (WAIT_STATES > 0) begin : g_capture
            logic        cap_vld_p1;
            logic [31:0] dout_p2;
            always_ff @(posedge clk) begin
                if (rst) cap_vld_p1 <= 1'b0;
                else     cap_vld_p1 <= sram_en && !dmem.dmem_cmd;
            end
            always_ff @(posedge clk) begin
                if (cap_vld_p1) dout_p2 <= sram_dout;
            end
            assign rd_word = dout_p2;
        end else begin : g_direct
            assign rd_word = sram_dout;
        end
    endgenerate

    assign resp_vld        = !rst && state == RESP;
    assign dmem.dmem_resp  = resp_vld ? (err_p1 ? 2'b10 : 2'b01) : 2'b00;
    assign dmem.dmem_rdata = (resp_vld && !cmd_p1 && !err_p1)
                           ? `YCR1_DMEM_DWIDTH'(rd_align(rd_word, width_p1, off_p1))
                           : '0;

endmodule

// File: tb/tb_ycr1_dmem_sram_resp.sv
// Directed bench for ycr1_dmem_sram_resp: zero-wait instance for the data path, three-wait instance for latency and reset.
`timescale 1ns/1ps

module tb_ycr1_dmem_sram_resp;

    logic clk;
    logic rst0, rst1;
    int   n_tests = 0;
    int   n_fail  = 0;

    ycr1_dmem_sram_resp_if if0 ();
    ycr1_dmem_sram_resp_if if1 ();

    logic        csb0, web0, csb1, web1;
    logic [3:0]  wmask0, wmask1;
    logic [8:0]  saddr0, saddr1;
    logic [31:0] din0, din1, dout0, dout1;
    logic [31:0] mem0 [512];
    logic [31:0] mem1 [512];

    ycr1_dmem_sram_resp #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst0), .dmem(if0),
        .sram_csb(csb0), .sram_web(web0), .sram_wmask(wmask0),
        .sram_addr(saddr0), .sram_din(din0), .sram_dout(dout0)
    );

    ycr1_dmem_sram_resp #(.WAIT_STATES(3)) u1 (
        .clk(clk), .rst(rst1), .dmem(if1),
        .sram_csb(csb1), .sram_web(web1), .sram_wmask(wmask1),
        .sram_addr(saddr1), .sram_din(din1), .sram_dout(dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < 4; i++)
                    if (wmask0[i]) mem0[saddr0][8*i +: 8] <= din0[8*i +: 8];
            end else begin
                dout0 <= mem0[saddr0];
            end
        end
    end

    always @(posedge clk) begin
        if (!csb1) begin
            if (!web1) begin
                for (int i = 0; i < 4; i++)
                    if (wmask1[i]) mem1[saddr1][8*i +: 8] <= din1[8*i +: 8];
            end else begin
                dout1 <= mem1[saddr1];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        cmd;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        csb;
        logic        web;
        logic [3:0]  wmask;
        logic [8:0]  saddr;
        logic [31:0] din;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic req, input logic cmd, input logic [1:0] width,
                          input logic [31:0] addr, input logic [31:0] wdata);
        if0.dmem_req   = req;
        if0.dmem_cmd   = cmd;
        if0.dmem_width = width;
        if0.dmem_addr  = addr;
        if0.dmem_wdata = wdata;
    endtask

    task automatic drive1(input logic req, input logic cmd, input logic [1:0] width,
                          input logic [31:0] addr, input logic [31:0] wdata);
        if1.dmem_req   = req;
        if1.dmem_cmd   = cmd;
        if1.dmem_width = width;
        if1.dmem_addr  = addr;
        if1.dmem_wdata = wdata;
    endtask

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{1'b1, 2'b10, 32'h0001_0010, 32'hDEAD_BEEF, 2'b01, 32'h0, 1'b0, 1'b0, 4'b1111, 9'd4, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 2'b10, 32'h0001_0010, 32'h0, 2'b01, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b1111, 9'd4, 32'h0};
        vecs[2]  = '{1'b1, 2'b00, 32'h0001_0013, 32'h0000_00A5, 2'b01, 32'h0, 1'b0, 1'b0, 4'b1000, 9'd4, 32'hA500_0000};
        vecs[3]  = '{1'b0, 2'b10, 32'h0001_0010, 32'h0, 2'b01, 32'hA5AD_BEEF, 1'b0, 1'b1, 4'b1111, 9'd4, 32'h0};
        vecs[4]  = '{1'b0, 2'b01, 32'h0001_0012, 32'h0, 2'b01, 32'h0000_A5AD, 1'b0, 1'b1, 4'b1100, 9'd4, 32'h0};
        vecs[5]  = '{1'b0, 2'b00, 32'h0001_0011, 32'h0, 2'b01, 32'h0000_00BE, 1'b0, 1'b1, 4'b0010, 9'd4, 32'h0};
        vecs[6]  = '{1'b1, 2'b01, 32'h0001_0016, 32'h0000_1234, 2'b01, 32'h0, 1'b0, 1'b0, 4'b1100, 9'd5, 32'h1234_0000};
        vecs[7]  = '{1'b0, 2'b01, 32'h0001_0016, 32'h0, 2'b01, 32'h0000_1234, 1'b0, 1'b1, 4'b1100, 9'd5, 32'h0};
        vecs[8]  = '{1'b0, 2'b10, 32'h0002_0000, 32'h0, 2'b10, 32'h0, 1'b1, 1'b1, 4'b0000, 9'd0, 32'h0};
        vecs[9]  = '{1'b0, 2'b11, 32'h0001_0010, 32'h0, 2'b10, 32'h0, 1'b1, 1'b1, 4'b0000, 9'd0, 32'h0};
        vecs[10] = '{1'b1, 2'b10, 32'h0002_0010, 32'h1122_3344, 2'b10, 32'h0, 1'b1, 1'b1, 4'b0000, 9'd0, 32'h0};
`ifdef YCR1_DMEM_SRAM_ALIGN_CHK_EN
        vecs[11] = '{1'b0, 2'b10, 32'h0001_0012, 32'h0, 2'b10, 32'h0, 1'b1, 1'b1, 4'b0000, 9'd0, 32'h0};
        vecs[12] = '{1'b0, 2'b01, 32'h0001_0011, 32'h0, 2'b10, 32'h0, 1'b1, 1'b1, 4'b0000, 9'd0, 32'h0};
`else
        vecs[11] = '{1'b0, 2'b10, 32'h0001_0012, 32'h0, 2'b01, 32'hA5AD_BEEF, 1'b0, 1'b1, 4'b1111, 9'd4, 32'h0};
        vecs[12] = '{1'b0, 2'b01, 32'h0001_0011, 32'h0, 2'b01, 32'h0000_BEEF, 1'b0, 1'b1, 4'b0011, 9'd4, 32'h0};
`endif

        // Reset with a live request on both ports: nothing may be accepted or written
        rst0 = 1'b1;
        rst1 = 1'b1;
        drive0(1'b1, 1'b1, 2'b10, 32'h0001_0010, 32'hFFFF_FFFF);
        drive1(1'b1, 1'b1, 2'b10, 32'h0001_0010, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        #2;
        check("rst_ack",   32'(if0.dmem_req_ack), 32'h0);
        check("rst_resp",  32'(if0.dmem_resp),    32'h0);
        check("rst_rdata", if0.dmem_rdata,        32'h0);
        check("rst_csb",   32'(csb0),             32'h1);
        check("rst_web",   32'(web0),             32'h1);
        check("rst_wmask", 32'(wmask0),           32'h0);
        check("rst_saddr", 32'(saddr0),           32'h0);
        check("rst_din",   din0,                  32'h0);
        check("rst1_ack",  32'(if1.dmem_req_ack), 32'h0);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #2;
        check("post_rst_ack",   32'(if0.dmem_req_ack), 32'h1);
        check("post_rst_resp",  32'(if0.dmem_resp),    32'h0);
        check("post_rst_rdata", if0.dmem_rdata,        32'h0);
        check("post_rst_csb",   32'(csb0),             32'h1);

        // Single transfers, zero wait states
        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            drive0(1'b1, vecs[v].cmd, vecs[v].width, vecs[v].addr, vecs[v].wdata);
            #2;
            check($sformatf("v%0d_ack", v),   32'(if0.dmem_req_ack), 32'h1);
            check($sformatf("v%0d_csb", v),   32'(csb0),             32'(vecs[v].csb));
            check($sformatf("v%0d_web", v),   32'(web0),             32'(vecs[v].web));
            check($sformatf("v%0d_wmask", v), 32'(wmask0),           32'(vecs[v].wmask));
            check($sformatf("v%0d_saddr", v), 32'(saddr0),           32'(vecs[v].saddr));
            check($sformatf("v%0d_din", v),   din0,                  vecs[v].din);
            @(negedge clk);
            drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            #2;
            check($sformatf("v%0d_resp", v),  32'(if0.dmem_resp), 32'(vecs[v].resp));
            check($sformatf("v%0d_rdata", v), if0.dmem_rdata,     vecs[v].rdata);
            @(negedge clk);
            #2;
            check($sformatf("v%0d_idle_resp", v), 32'(if0.dmem_resp), 32'h0);
        end

        // Four back-to-back reads with req held high
        @(negedge clk);
        drive0(1'b1, 1'b0, 2'b10, 32'h0001_0010, 32'h0);
        #2;
        check("b2b0_ack",  32'(if0.dmem_req_ack), 32'h1);
        check("b2b0_resp", 32'(if0.dmem_resp),    32'h0);
        @(negedge clk);
        drive0(1'b1, 1'b0, 2'b01, 32'h0001_0016, 32'h0);
        #2;
        check("b2b1_ack",   32'(if0.dmem_req_ack), 32'h1);
        check("b2b1_resp",  32'(if0.dmem_resp),    32'h1);
        check("b2b1_rdata", if0.dmem_rdata,        32'hA5AD_BEEF);
        @(negedge clk);
        drive0(1'b1, 1'b0, 2'b00, 32'h0001_0011, 32'h0);
        #2;
        check("b2b2_ack",   32'(if0.dmem_req_ack), 32'h1);
        check("b2b2_resp",  32'(if0.dmem_resp),    32'h1);
        check("b2b2_rdata", if0.dmem_rdata,        32'h0000_1234);
        @(negedge clk);
        drive0(1'b1, 1'b0, 2'b10, 32'h0001_0014, 32'h0);
        #2;
        check("b2b3_ack",   32'(if0.dmem_req_ack), 32'h1);
        check("b2b3_resp",  32'(if0.dmem_resp),    32'h1);
        check("b2b3_rdata", if0.dmem_rdata,        32'h0000_00BE);
        @(negedge clk);
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #2;
        check("b2b4_resp",  32'(if0.dmem_resp), 32'h1);
        check("b2b4_rdata", if0.dmem_rdata,     mem0[5]);
        check("b2b4_hi",    32'(if0.dmem_rdata[31:16]), 32'h1234);
        @(negedge clk);
        #2;
        check("b2b5_resp",  32'(if0.dmem_resp), 32'h0);

        // Three wait states: write then read, response four cycles after accept
        @(negedge clk);
        drive1(1'b1, 1'b1, 2'b10, 32'h0001_0008, 32'hCAFE_F00D);
        #2;
        check("ws_wr_csb",   32'(csb1),   32'h0);
        check("ws_wr_web",   32'(web1),   32'h0);
        check("ws_wr_saddr", 32'(saddr1), 32'h2);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            #2;
            check($sformatf("ws_wr_wait%0d_resp", c), 32'(if1.dmem_resp),    32'h0);
            check($sformatf("ws_wr_wait%0d_ack", c),  32'(if1.dmem_req_ack), 32'h0);
        end
        @(negedge clk);
        #2;
        check("ws_wr_resp", 32'(if1.dmem_resp),    32'h1);
        check("ws_wr_ack",  32'(if1.dmem_req_ack), 32'h1);
        @(negedge clk);
        drive1(1'b1, 1'b0, 2'b10, 32'h0001_0008, 32'h0);
        #2;
        check("ws_rd_csb", 32'(csb1), 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            #2;
            check($sformatf("ws_rd_wait%0d_resp", c), 32'(if1.dmem_resp), 32'h0);
        end
        @(negedge clk);
        #2;
        check("ws_rd_resp",  32'(if1.dmem_resp), 32'h1);
        check("ws_rd_rdata", if1.dmem_rdata,     32'hCAFE_F00D);

        // Reset two cycles after acceptance drops the pending response
        @(negedge clk);
        drive1(1'b1, 1'b0, 2'b10, 32'h0001_0008, 32'h0);
        @(negedge clk);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #2;
        check("wr_rst_pre_resp", 32'(if1.dmem_resp), 32'h0);
        @(negedge clk);
        rst1 = 1'b1;
        #2;
        check("wr_rst_ack",  32'(if1.dmem_req_ack), 32'h0);
        check("wr_rst_resp", 32'(if1.dmem_resp),    32'h0);
        @(negedge clk);
        rst1 = 1'b0;
        #2;
        check("wr_rst_rel_ack",  32'(if1.dmem_req_ack), 32'h1);
        check("wr_rst_rel_resp", 32'(if1.dmem_resp),    32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #2;
            check($sformatf("wr_rst_late%0d_resp", c), 32'(if1.dmem_resp),    32'h0);
            check($sformatf("wr_rst_late%0d_ack", c),  32'(if1.dmem_req_ack), 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
